// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding and counter-width helper
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/fa.sv
// fa: single-bit full adder cell
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full-adder cell over WIDTH bits
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_c;
  fa u_fa (r_a_sh[0], r_b_sh[0], r_carry, w_s, w_c);
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum_sh;
  assign cout      = r_carry;
  // sequencer: load operands, shift one bit pair per cycle LSB first, hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a_sh   <= a;
          r_b_sh   <= b;
          r_carry  <= cin;
          r_sum_sh <= '0;
          r_cnt    <= '0;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= WIDTH'({w_s, r_sum_sh} >> 1);
          r_carry  <= w_c;
          r_cnt    <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and swept checks of the bit-serial adder at WIDTH 8, 1 and 16
module tb_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv8, ir8, cin8, ov8, or8, co8, bz8;
  logic [7:0]  a8, b8, s8;
  logic        iv1, ir1, cin1, ov1, or1, co1, bz1;
  logic [0:0]  a1, b1, s1;
  logic        iv16, ir16, cin16, ov16, or16, co16, bz16;
  logic [15:0] a16, b16, s16;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1));
  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(bz16));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [8:0] exp);
    iv8 = 1'b1; a8 = x; b8 = y; cin8 = c; or8 = 1'b1;
    check({tag, "_ready"}, ir8, 1'b1);
    step();
    iv8 = 1'b0;
    check({tag, "_busy"}, bz8, 1'b1);
    repeat (7) step();
    check({tag, "_early"}, ov8, 1'b0);
    step();
    check({tag, "_valid"}, ov8, 1'b1);
    check({tag, "_result"}, {co8, s8}, exp);
    step();
    check({tag, "_idle"}, {ov8, bz8, ir8}, 3'b001);
  endtask

  initial begin
    logic [16:0] e16;
    logic [1:0]  e1;
    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; or8 = 0;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; or1 = 0;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; or16 = 0;
    step();
    step();
    check("rst_outs", {ir8, ov8, bz8, co8}, 4'b0000);
    check("rst_sum", s8, 8'h00);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", ir8, 1'b1);

    run8("basic", 8'h5A, 8'h3C, 1'b0, 9'h096);
    run8("ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
    run8("allones", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // backpressure in DONE
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; or8 = 1'b0;
    step();
    iv8 = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_flags", {ov8, ir8, bz8}, 3'b101);
      check("bp_hold_result", {co8, s8}, 9'h046);
      step();
    end
    check("bp_still_valid", ov8, 1'b1);
    or8 = 1'b1;
    step();
    check("bp_release", {ov8, bz8, ir8}, 3'b001);

    // in_valid held through RUN must be ignored
    iv8 = 1'b1; a8 = 8'h20; b8 = 8'h03; cin8 = 1'b1;
    step();
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    repeat (7) step();
    check("busy_ignore_ready", ir8, 1'b0);
    step();
    check("busy_first_result", {ov8, co8, s8}, 10'h224);
    step();
    check("busy_back_idle", {ov8, ir8}, 2'b01);
    step();
    iv8 = 1'b0;
    check("busy_second_accepted", bz8, 1'b1);
    repeat (8) step();
    check("busy_second_result", {ov8, co8, s8}, 10'h233);
    step();

    // reset in the middle of RUN
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1;
    step();
    iv8 = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_ready_forced", ir8, 1'b0);
    step();
    check("midrst_state", {ov8, bz8, co8}, 3'b000);
    check("midrst_sum", s8, 8'h00);
    rst_n = 1'b1;
    repeat (10) step();
    check("midrst_no_pulse", ov8, 1'b0);
    run8("after_rst", 8'h01, 8'h01, 1'b0, 9'h002);

    // WIDTH=1 exhaustive
    or1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; iv1 = 1'b1;
      e1 = {1'b0, i[2]} + {1'b0, i[1]} + {1'b0, i[0]};
      step();
      iv1 = 1'b0;
      check("w1_run", {bz1, ov1}, 2'b10);
      step();
      check("w1_valid", ov1, 1'b1);
      check("w1_result", {co1, s1}, e1);
      step();
    end

    // WIDTH=16 random sweep
    or16 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      e16 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
      iv16 = 1'b1;
      step();
      iv16 = 1'b0;
      repeat (15) step();
      check("w16_early", ov16, 1'b0);
      step();
      check("w16_result", {ov16, co16, s16}, {1'b1, e16});
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition sequencer that time-multiplexes a single `fa` full-adder cell across WIDTH-bit operands.
- Accepts two operands plus carry-in through a valid/ready input handshake.
- Feeds one bit pair per cycle, LSB first, through the `fa` instance and shifts the sum bits back in.
- Returns the WIDTH-bit sum and carry-out through a valid/ready output handshake.
- Serves as the area-minimal adder option beside the parallel ripple-carry adder.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH) (minimum 1), derived bit-counter width; not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands a, b, cin present.
- in_ready  output  1  block can accept operands (IDLE and not in reset).
- a  input  WIDTH  operand A; sampled only at input handshake.
- b  input  WIDTH  operand B; sampled only at input handshake.
- cin  input  1  carry-in; sampled only at input handshake.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered sum, valid while out_valid=1.
- cout  output  1  registered carry-out, valid while out_valid=1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n=0 at a rising edge), regardless of current state or any in-flight operation:
  - state goes to IDLE.
  - Shift registers, carry register, bit counter, sum and cout all clear to 0.
  - out_valid=0 and busy=0.
  - in_ready is forced to 0 while rst_n=0.
  - A reset during RUN or DONE discards the operation; no out_valid pulse follows.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0; go to RUN.
  - Otherwise hold.
- RUN:
  - Combinational `fa` inputs: a_sh[0], b_sh[0], carry.
  - Each edge:
    - a_sh and b_sh shift right by one.
    - sum_sh <= {fa.sum, sum_sh[WIDTH-1:1]}.
    - carry <= fa.carry.
    - cnt <= cnt+1.
  - When cnt==WIDTH-1, the same edge moves to DONE.
  - RUN lasts exactly WIDTH cycles.
  - in_valid is ignored (in_ready=0).
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry.
  - sum and cout are stable until the output handshake.
  - On out_valid & out_ready: go to IDLE; in_ready rises the following cycle (no same-cycle restart).
- Latency: input handshake at edge E0 -> out_valid visible after edge E0+WIDTH.
- Minimum initiation interval: WIDTH+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), no overflow flag.
- WIDTH=1: RUN lasts one cycle; the counter stays at 0 and the transition is taken immediately.
- out_ready held high before DONE has no effect.
- in_valid may drop without acceptance; no state change results.

Decomposition:
- Shared package: state encoding constants (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and the counter-width helper function.
- Sub-module: instantiate the existing `fa` cell once, positionally (a, b, c, sum, carry), for the per-bit arithmetic. No new sub-module.
- Controller and shift registers stay in serial_add_ctrl.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid exactly 8 cycles after the handshake edge; sum=0x96, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout held constant, in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1 the cycle after the handshake.
- Input during busy: in_valid=1 with a=0x11 asserted for all of RUN -> ignored; result equals the first operands. 0x11 accepted only once back in IDLE.
- Reset mid-operation: rst_n=0 for 1 cycle at RUN cycle 3 -> next cycle IDLE, out_valid=0, busy=0, sum=0. A subsequent 0x01+0x01 yields 0x02 with no stale carry.
- Parameter sweep: WIDTH=1 with all 8 {a,b,cin} combos -> correct {cout,sum} after 1 cycle. WIDTH=16 random 1000 ops vs a+b+cin -> all match.
